// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the PRBS4 generator/checker pair.
//   state_e          : checker synchronisation states
//   PRBS4_TAP_HI/LO  : feedback taps of x^4+x^3+1 (shift-left, feedback to bit 0)
//   PRBS4_PERIOD     : sequence length of the maximal-length 4-bit LFSR
//   prbs4_predict()  : next serial bit predicted from a 4-bit history
// -----------------------------------------------------------------------------
package prbs_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int PRBS4_TAP_HI = 3;
    localparam int PRBS4_TAP_LO = 2;
    localparam int PRBS4_PERIOD = 15;

    // History holds the last four received bits, oldest in bit 3.
    function automatic logic prbs4_predict(input logic [3:0] hist);
        return hist[PRBS4_TAP_HI] ^ hist[PRBS4_TAP_LO];
    endfunction

endpackage

// File: rtl/prbs4_checker_if.sv
// -----------------------------------------------------------------------------
// prbs4_checker_if
// Stream and status bundle between a PRBS source/monitor and prbs4_checker.
//   din_valid, din, clear_cnt : stream input and counter clear (master drives)
//   locked, bit_err, lock_lost, err_count : checker status (slave drives)
// -----------------------------------------------------------------------------
interface prbs4_checker_if #(
    parameter int CNT_W = 16
);
    logic             din_valid;
    logic             din;
    logic             clear_cnt;
    logic             locked;
    logic             bit_err;
    logic             lock_lost;
    logic [CNT_W-1:0] err_count;

    modport master (
        output din_valid, din, clear_cnt,
        input  locked, bit_err, lock_lost, err_count
    );

    modport slave (
        input  din_valid, din, clear_cnt,
        output locked, bit_err, lock_lost, err_count
    );
endinterface

// File: rtl/prbs_err_window.sv
// -----------------------------------------------------------------------------
// prbs_err_window
// Block-window error density monitor used while the checker is locked.
//   clk, rst      : clock, asynchronous active-high reset
//   valid_i       : one bit checked this cycle
//   mismatch_i    : that bit was wrong
//   clear_i       : hold window position and error count at zero
//   thresh_hit_o  : combinational strobe, this bit is the ERR_THRESH-th error
//                   of the current window
// -----------------------------------------------------------------------------
module prbs_err_window #(
    parameter int ERR_WIN    = 16,
    parameter int ERR_THRESH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    input  logic mismatch_i,
    input  logic clear_i,
    output logic thresh_hit_o
);
    localparam int POS_W  = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
    localparam int ERRC_W = $clog2(ERR_THRESH + 1);

    logic [POS_W-1:0]  win_pos_q, win_pos_d;
    logic [ERRC_W-1:0] win_err_q, win_err_d;

    // Threshold is judged on the bit being checked, so a hit wins over a wrap.
    assign thresh_hit_o = ~clear_i & valid_i & mismatch_i &
                          (win_err_q == ERRC_W'(ERR_THRESH - 1));

    // Next window position and per-window error count.
    always_comb begin
        win_pos_d = win_pos_q;
        win_err_d = win_err_q;
        if (clear_i) begin
            win_pos_d = '0;
            win_err_d = '0;
        end else if (valid_i) begin
            if (thresh_hit_o) begin
                win_pos_d = '0;
                win_err_d = '0;
            end else if (win_pos_q == POS_W'(ERR_WIN - 1)) begin
                win_pos_d = '0;
                win_err_d = '0;
            end else begin
                win_pos_d = win_pos_q + POS_W'(1);
                win_err_d = win_err_q + ERRC_W'(mismatch_i);
            end
        end else begin
            win_pos_d = win_pos_q;
            win_err_d = win_err_q;
        end
    end

    // Window state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_pos_q <= '0;
            win_err_q <= '0;
        end else begin
            win_pos_q <= win_pos_d;
            win_err_q <= win_err_d;
        end
    end
endmodule

// File: rtl/prbs4_checker.sv
// -----------------------------------------------------------------------------
// prbs4_checker
// Self-synchronising checker for the x^4+x^3+1 serial PRBS stream.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : prbs4_checker_if.slave
//     din_valid/din : received stream, state advances only on valid bits
//     clear_cnt     : synchronous clear of err_count (wins over increment)
//     locked        : high while LOCKED
//     bit_err       : pulse, previous valid bit mismatched while LOCKED
//     lock_lost     : pulse on LOCKED -> SEARCH
//     err_count     : saturating mismatch count, LOCKED only
// -----------------------------------------------------------------------------
module prbs4_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT   = 8,
    parameter int ERR_WIN    = 16,
    parameter int ERR_THRESH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    prbs4_checker_if.slave       bus
);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);

    state_e             state_q, state_d;
    logic [3:0]         h_q, h_d;
    logic [2:0]         fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;

    logic               locked_q, locked_d;
    logic               bit_err_q, bit_err_d;
    logic               lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic pred_s;
    logic mismatch_s;
    logic lock_valid_s;
    logic win_clear_s;
    logic thresh_hit_s;

    assign pred_s       = prbs4_predict(h_q);
    assign mismatch_s   = bus.din ^ pred_s;
    assign lock_valid_s = bus.din_valid & (state_q == LOCKED);
    // Window counters are held at zero outside LOCKED, so they start fresh at lock.
    assign win_clear_s  = (state_q != LOCKED);

    prbs_err_window #(
        .ERR_WIN    (ERR_WIN),
        .ERR_THRESH (ERR_THRESH)
    ) u_err_window (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (lock_valid_s),
        .mismatch_i   (mismatch_s),
        .clear_i      (win_clear_s),
        .thresh_hit_o (thresh_hit_s)
    );

    // FSM state and predictor history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEARCH;
            h_q     <= 4'd0;
            fill_q  <= 3'd0;
            match_q <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    // Next-state and history update.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        fill_d  = fill_q;
        match_d = match_q;
        if (bus.din_valid) begin
            case (state_q)
                SEARCH: begin
                    h_d    = {h_q[2:0], bus.din};
                    fill_d = fill_q + 3'd1;
                    if (fill_q == 3'd3) begin
                        match_d = '0;
                        state_d = VERIFY;
                    end else begin
                        state_d = SEARCH;
                    end
                end
                VERIFY: begin
                    h_d = {h_q[2:0], bus.din};
                    // All-zero history is a dead LFSR state and never counts.
                    if (!mismatch_s && (h_q != 4'd0)) begin
                        match_d = match_q + MATCH_W'(1);
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                        end else begin
                            state_d = VERIFY;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    if (thresh_hit_s) begin
                        state_d = SEARCH;
                        h_d     = 4'd0;
                        fill_d  = 3'd0;
                        match_d = '0;
                    end else begin
                        // Free-run on the prediction so a bad bit cannot corrupt h.
                        h_d = {h_q[2:0], pred_s};
                    end
                end
                default: begin
                    state_d = SEARCH;
                    h_d     = 4'd0;
                    fill_d  = 3'd0;
                    match_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
            h_d     = h_q;
            fill_d  = fill_q;
            match_d = match_q;
        end
    end

    // Next values of the registered status outputs.
    always_comb begin
        locked_d    = (state_d == LOCKED);
        bit_err_d   = lock_valid_s & mismatch_s;
        lock_lost_d = lock_valid_s & thresh_hit_s;
        if (bus.clear_cnt) begin
            err_count_d = '0;
        end else if (lock_valid_s && mismatch_s && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_q    <= 1'b0;
            bit_err_q   <= 1'b0;
            lock_lost_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            locked_q    <= locked_d;
            bit_err_q   <= bit_err_d;
            lock_lost_q <= lock_lost_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.bit_err   = bit_err_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.err_count = err_count_q;
endmodule
